core_fpu_sched: RTL and testbench

//  Sequences one FP operation at a time onto the four AXI-Stream FP units (ADDSUB, MUL, DIV, COMP).

---
 rtl/core_fpu_sched_if.sv | 31 +++
 rtl/core_fpu_sched.sv | 213 +++++++++++++++++++++
 tb/tb_core_fpu_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_fpu_sched_if.sv
// Unit-side bus of the FP scheduler: shared operand/op buses, per-unit
// AXI-Stream valid/ready lanes ordered {COMP,DIV,MUL,ADDSUB}, and the packed
// result bus. The scheduler is the master, the FP IP cores are the slave.
interface core_fpu_sched_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   U_A_TDATA;
    logic [3:0]          U_A_TVALID;
    logic [3:0]          U_A_TREADY;
    logic [DATA_W-1:0]   U_B_TDATA;
    logic [3:0]          U_B_TVALID;
    logic [3:0]          U_B_TREADY;
    logic [7:0]          U_OP_TDATA;
    logic [1:0]          U_OP_TVALID;   // {COMP,ADDSUB}
    logic [1:0]          U_OP_TREADY;
    logic [4*DATA_W-1:0] U_R_TDATA;
    logic [3:0]          U_R_TVALID;
    logic [3:0]          U_R_TREADY;

    modport master (
        output U_A_TDATA, U_A_TVALID, U_B_TDATA, U_B_TVALID,
               U_OP_TDATA, U_OP_TVALID, U_R_TREADY,
        input  U_A_TREADY, U_B_TREADY, U_OP_TREADY, U_R_TDATA, U_R_TVALID
    );

    modport slave (
        input  U_A_TDATA, U_A_TVALID, U_B_TDATA, U_B_TVALID,
               U_OP_TDATA, U_OP_TVALID, U_R_TREADY,
        output U_A_TREADY, U_B_TREADY, U_OP_TREADY, U_R_TDATA, U_R_TVALID
    );
endinterface

// File: rtl/core_fpu_sched.sv
// One-at-a-time FP operation sequencer. Accepts a request from the execute
// stage, pushes operands (and op code for ADDSUB/COMP) to the selected unit,
// collects one result, and returns it with a one-cycle strobe. BUSY stalls
// the core for the whole operation. A watchdog turns a hung unit into an
// error response.
module core_fpu_sched #(
    parameter int DATA_W = 32,
    parameter int TMO_W  = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [2:0]        REQ_OP,
    input  logic [DATA_W-1:0] REQ_A,
    input  logic [DATA_W-1:0] REQ_B,
    output logic              BUSY,
    output logic              RESP_VALID,
    output logic [DATA_W-1:0] RESP_DATA,
    output logic              RESP_ERR,
    core_fpu_sched_if.master  u_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Operand channel index into the valid/sent vectors.
    localparam int CH_A  = 0;
    localparam int CH_B  = 1;
    localparam int CH_OP = 2;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        valid_q, valid_d;   // per channel {OP,B,A}
    logic [2:0]        sent_q, sent_d;
    logic              cap_q, cap_d;       // result already taken in ISSUE
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_err_q;

    logic [3:0]        sel_unit;
    logic [1:0]        sel_op;
    logic [1:0]        unit_idx;
    logic [2:0]        need;
    logic [7:0]        op_code;
    logic              active;
    logic [2:0]        chan_rdy;
    logic [2:0]        sent_now;
    logic              r_hs;
    logic              have_res;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_hit;
    logic [DATA_W-1:0] r_slice;
    logic [DATA_W-1:0] r_value;

    // Decode the latched op into target unit, required channels and op code.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path can leave it unassigned and infer a latch.
        sel_unit = 4'b0000;
        unit_idx = 2'd0;
        need     = 3'b011;
        op_code  = 8'h00;
        case (op_q)
            3'd0: begin sel_unit = 4'b0001; unit_idx = 2'd0; need = 3'b111; op_code = 8'h00; end
            3'd1: begin sel_unit = 4'b0001; unit_idx = 2'd0; need = 3'b111; op_code = 8'h01; end
            3'd2: begin sel_unit = 4'b0010; unit_idx = 2'd1; end
            3'd3: begin sel_unit = 4'b0100; unit_idx = 2'd2; end
            3'd4: begin sel_unit = 4'b1000; unit_idx = 2'd3; need = 3'b111; op_code = 8'h14; end
            3'd5: begin sel_unit = 4'b1000; unit_idx = 2'd3; need = 3'b111; op_code = 8'h0C; end
            3'd6: begin sel_unit = 4'b1000; unit_idx = 2'd3; need = 3'b111; op_code = 8'h1C; end
            default: need = 3'b000;
        endcase
        sel_op = {sel_unit[3], sel_unit[0]};
    end

    // Handshake status, result selection and watchdog compare.
    always_comb begin
        active          = (state_q == S_ISSUE) || (state_q == S_WAIT);
        chan_rdy[CH_A]  = |(u_if.U_A_TREADY & sel_unit);
        chan_rdy[CH_B]  = |(u_if.U_B_TREADY & sel_unit);
        chan_rdy[CH_OP] = |(u_if.U_OP_TREADY & sel_op);
        // Channels the op does not use count as already sent.
        sent_now        = sent_q | (valid_q & chan_rdy) | ~need;
        r_hs            = active && !cap_q && |(u_if.U_R_TVALID & sel_unit);
        have_res        = cap_q || r_hs;
        tmo_inc         = tmo_q + 1'b1;
        tmo_hit         = active && (tmo_inc == '1);
        r_slice         = u_if.U_R_TDATA[int'(unit_idx) * DATA_W +: DATA_W];
        // COMP returns a flag in bit 0; widen it to a clean 0/1 word.
        r_value         = (unit_idx == 2'd3) ? {{(DATA_W-1){1'b0}}, r_slice[0]} : r_slice;
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = 3'b000;
        sent_d   = sent_q;
        cap_d    = cap_q;
        result_d = result_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    op_d     = REQ_OP;
                    a_d      = REQ_A;
                    b_d      = REQ_B;
                    sent_d   = 3'b000;
                    cap_d    = 1'b0;
                    result_d = '0;
                    tmo_d    = '0;
                    err_d    = (REQ_OP == 3'd7);
                    state_d  = (REQ_OP == 3'd7) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                sent_d = sent_now;
                cap_d  = have_res;
                tmo_d  = tmo_inc;
                if (r_hs) begin
                    result_d = r_value;
                end
                if ((&sent_now) && have_res) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    result_d = '0;
                end else if (&sent_now) begin
                    state_d = S_WAIT;
                end else begin
                    // Still issuing: keep offering every channel not yet taken.
                    valid_d = ~sent_now;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and datapath registers, synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!RST_N) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 3'b000;
            sent_q   <= 3'b000;
            cap_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            sent_q   <= sent_d;
            cap_q    <= cap_d;
            result_q <= result_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    // Response strobe: one cycle out of DONE; data held until the next strobe.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= (state_q == S_DONE);
            resp_err_q   <= (state_q == S_DONE) && err_q;
            if (state_q == S_DONE) begin
                resp_data_q <= result_q;
            end
        end
    end

    assign REQ_READY  = (state_q == S_IDLE);
    assign BUSY       = (state_q != S_IDLE);
    assign RESP_VALID = resp_valid_q;
    assign RESP_DATA  = resp_data_q;
    assign RESP_ERR   = resp_err_q;

    // Operand buses come straight from the request latches, so they stay
    // stable for as long as any valid is up.
    assign u_if.U_A_TDATA   = a_q;
    assign u_if.U_B_TDATA   = b_q;
    assign u_if.U_OP_TDATA  = op_code;
    assign u_if.U_A_TVALID  = valid_q[CH_A]  ? sel_unit : 4'b0000;
    assign u_if.U_B_TVALID  = valid_q[CH_B]  ? sel_unit : 4'b0000;
    assign u_if.U_OP_TVALID = valid_q[CH_OP] ? sel_op   : 2'b00;
    assign u_if.U_R_TREADY  = (active && !cap_q) ? sel_unit : 4'b0000;

endmodule

// File: tb/tb_core_fpu_sched.sv
// Self-checking bench for core_fpu_sched: behavioural FP-unit responders with
// configurable ready/result delays and an op-table reference model.
module tb_core_fpu_sched;

    localparam int DATA_W  = 32;
    localparam int TMO_W   = 10;
    localparam int TMO_CYC = (1 << TMO_W) - 1;
    localparam int LIMIT   = 1200;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              REQ_VALID = 1'b0;
    logic              REQ_READY;
    logic [2:0]        REQ_OP = 3'd0;
    logic [DATA_W-1:0] REQ_A = '0;
    logic [DATA_W-1:0] REQ_B = '0;
    logic              BUSY;
    logic              RESP_VALID;
    logic [DATA_W-1:0] RESP_DATA;
    logic              RESP_ERR;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    core_fpu_sched_if #(.DATA_W(DATA_W)) uif ();

    core_fpu_sched #(.DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_OP     (REQ_OP),
        .REQ_A      (REQ_A),
        .REQ_B      (REQ_B),
        .BUSY       (BUSY),
        .RESP_VALID (RESP_VALID),
        .RESP_DATA  (RESP_DATA),
        .RESP_ERR   (RESP_ERR),
        .u_if       (uif)
    );

    // Op table of the reference model: target unit (-1 = illegal) and op code.
    function automatic int unit_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1:       return 0;
            3'd2:             return 1;
            3'd3:             return 2;
            3'd4, 3'd5, 3'd6: return 3;
            default:          return -1;
        endcase
    endfunction

    function automatic logic [7:0] opcode_of(input logic [2:0] op);
        case (op)
            3'd1:    return 8'h01;
            3'd4:    return 8'h14;
            3'd5:    return 8'h0C;
            3'd6:    return 8'h1C;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clear_units();
        uif.U_A_TREADY  = 4'b0;
        uif.U_B_TREADY  = 4'b0;
        uif.U_OP_TREADY = 2'b0;
        uif.U_R_TVALID  = 4'b0;
        uif.U_R_TDATA   = '0;
    endtask

    task automatic check_quiet(input string name);
        total++;
        if (uif.U_A_TVALID !== 4'b0 || uif.U_B_TVALID !== 4'b0 || uif.U_OP_TVALID !== 2'b0 ||
            uif.U_R_TREADY !== 4'b0 || BUSY !== 1'b0 || REQ_READY !== 1'b1 || RESP_VALID !== 1'b0) begin
            bad++;
            $display("FAIL %s quiet: a_v=%b b_v=%b op_v=%b r_rdy=%b busy=%b req_rdy=%b resp_v=%b, want all 0 except req_rdy=1",
                     name, uif.U_A_TVALID, uif.U_B_TVALID, uif.U_OP_TVALID, uif.U_R_TREADY,
                     BUSY, REQ_READY, RESP_VALID);
        end
    endtask

    // One complete operation. Starts and ends at a negedge.
    // rmode: 0 = result rdly cycles after operands taken, 1 = result offered
    // from the start, 2 = result never offered (watchdog).
    task automatic run_txn(input string name, input logic [2:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input int da, input int db, input int dop,
                           input int rmode, input int rdly,
                           input logic [DATA_W-1:0] rval, input bit noise);
        int u, r_cnt, r_edge, wait_cnt, resp_edge, exp_edge;
        bit legal, need_o, tmo_case, r_on, all_sent;
        int dly[3];
        int seen[3];
        bit rdy[3];
        int hs_cnt[3];
        int hs_edge[3];
        logic [3:0] sel;
        logic [3:0] vv[3];
        logic [3:0] msk[3];
        logic [DATA_W-1:0] exp_data;
        logic exp_err;
        logic [4*DATA_W-1:0] rbus;

        u        = unit_of(op);
        legal    = (u >= 0);
        sel      = legal ? 4'(1 << u) : 4'b0;
        need_o   = legal && (u == 0 || u == 3);
        tmo_case = legal && (rmode == 2);
        msk[0]   = sel;
        msk[1]   = sel;
        msk[2]   = need_o ? {2'b00, sel[3], sel[0]} : 4'b0;
        dly      = '{da, db, dop};
        for (int c = 0; c < 3; c++) begin
            seen[c] = 0; rdy[c] = 1'b0; hs_cnt[c] = 0; hs_edge[c] = 0;
        end
        r_cnt = 0; r_edge = 0; wait_cnt = 0; resp_edge = -1;
        r_on  = legal && (rmode == 1);

        REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_B = b;
        #1;
        total++;
        if (REQ_READY !== 1'b1) begin
            bad++;
            $display("FAIL %s req_ready: got %b want 1", name, REQ_READY);
        end
        @(posedge CLK);                       // acceptance edge (edge 0)
        @(negedge CLK);
        REQ_VALID = 1'b0; REQ_OP = 3'($urandom); REQ_A = $urandom; REQ_B = $urandom;

        for (int k = 0; k < LIMIT; k++) begin
            // Between edge k and edge k+1.
            vv[0] = uif.U_A_TVALID;
            vv[1] = uif.U_B_TVALID;
            vv[2] = {2'b00, uif.U_OP_TVALID};
            total++;
            if ((vv[0] & ~msk[0]) != 0 || (vv[1] & ~msk[1]) != 0 || (vv[2] & ~msk[2]) != 0 ||
                (uif.U_R_TREADY & ~sel) != 0) begin
                bad++;
                $display("FAIL %s stray_handshake @%0d: a_v=%b b_v=%b op_v=%b r_rdy=%b allowed=%b",
                         name, k, vv[0], vv[1], vv[2][1:0], uif.U_R_TREADY, sel);
            end
            if (k <= 1) begin
                total++;
                if (vv[0] !== (k == 1 ? msk[0] : 4'b0) || vv[1] !== (k == 1 ? msk[1] : 4'b0) ||
                    vv[2] !== (k == 1 ? msk[2] : 4'b0)) begin
                    bad++;
                    $display("FAIL %s valid_rise @%0d: a_v=%b b_v=%b op_v=%b want %b/%b/%b",
                             name, k, vv[0], vv[1], vv[2][1:0],
                             (k == 1 ? msk[0] : 4'b0), (k == 1 ? msk[1] : 4'b0),
                             (k == 1 ? msk[2][1:0] : 2'b0));
                end
            end
            if ((vv[0] | vv[1] | vv[2]) != 0) begin
                total++;
                if (uif.U_A_TDATA !== a || uif.U_B_TDATA !== b ||
                    (vv[2] != 0 && uif.U_OP_TDATA !== opcode_of(op))) begin
                    bad++;
                    $display("FAIL %s tdata @%0d: a=%h b=%h op=%h want %h %h %h",
                             name, k, uif.U_A_TDATA, uif.U_B_TDATA, uif.U_OP_TDATA, a, b, opcode_of(op));
                end
            end
            if (RESP_VALID === 1'b1) begin
                resp_edge = k;
                break;
            end

            // Request noise while busy must be ignored.
            if (noise && legal && k < 2) begin
                REQ_VALID = 1'b1; REQ_OP = 3'd7;
                total++;
                if (REQ_READY !== 1'b0) begin
                    bad++;
                    $display("FAIL %s req_ready_busy @%0d: got %b want 0", name, k, REQ_READY);
                end
            end else begin
                REQ_VALID = 1'b0;
            end

            for (int c = 0; c < 3; c++) begin
                if (vv[c] != 0) begin
                    seen[c]++;
                    if (seen[c] > dly[c]) rdy[c] = 1'b1;
                end
            end
            uif.U_A_TREADY  = {4{rdy[0]}};
            uif.U_B_TREADY  = {4{rdy[1]}};
            uif.U_OP_TREADY = {2{rdy[2]}};

            all_sent = (hs_cnt[0] > 0) && (hs_cnt[1] > 0) && (!need_o || hs_cnt[2] > 0);
            if (r_cnt > 0) r_on = 1'b0;
            else if (rmode == 0 && legal && all_sent) begin
                if (wait_cnt >= rdly) r_on = 1'b1;
                wait_cnt++;
            end
            uif.U_R_TVALID = r_on ? sel : 4'b0;
            rbus = {$urandom, $urandom, $urandom, $urandom};
            if (legal) rbus[u*DATA_W +: DATA_W] = rval;
            uif.U_R_TDATA = rbus;
            #1;
            for (int c = 0; c < 3; c++) begin
                if (vv[c] != 0 && rdy[c]) begin
                    hs_cnt[c]++;
                    hs_edge[c] = k + 1;
                end
            end
            if (r_on && (uif.U_R_TREADY & sel) != 0) begin
                r_cnt++;
                r_edge = k + 1;
            end
            @(negedge CLK);
        end

        REQ_VALID = 1'b0;
        clear_units();

        total++;
        if (resp_edge < 0) begin
            bad++;
            $display("FAIL %s no_response: none within %0d cycles, want one", name, LIMIT);
        end else begin
            exp_err  = !legal || tmo_case;
            exp_data = exp_err ? '0 : (u == 3 ? {{(DATA_W-1){1'b0}}, rval[0]} : rval);
            if (!legal)        exp_edge = 1;
            else if (tmo_case) exp_edge = TMO_CYC + 1;
            else begin
                exp_edge = r_edge;
                for (int c = 0; c < 3; c++) if (hs_edge[c] > exp_edge) exp_edge = hs_edge[c];
                exp_edge = exp_edge + 1;
            end

            total++;
            if (RESP_DATA !== exp_data || RESP_ERR !== exp_err) begin
                bad++;
                $display("FAIL %s resp: data=%h err=%b want data=%h err=%b",
                         name, RESP_DATA, RESP_ERR, exp_data, exp_err);
            end
            total++;
            if (resp_edge != exp_edge || (legal && resp_edge < 3)) begin
                bad++;
                $display("FAIL %s latency: resp at edge %0d want %0d", name, resp_edge, exp_edge);
            end
            total++;
            if (hs_cnt[0] != (legal ? 1 : 0) || hs_cnt[1] != (legal ? 1 : 0) ||
                hs_cnt[2] != (need_o ? 1 : 0) || r_cnt != ((legal && !tmo_case) ? 1 : 0)) begin
                bad++;
                $display("FAIL %s hs_count: a=%0d b=%0d op=%0d r=%0d want %0d %0d %0d %0d",
                         name, hs_cnt[0], hs_cnt[1], hs_cnt[2], r_cnt,
                         legal ? 1 : 0, legal ? 1 : 0, need_o ? 1 : 0, (legal && !tmo_case) ? 1 : 0);
            end
            @(negedge CLK);
            total++;
            if (RESP_DATA !== exp_data || RESP_ERR !== 1'b0) begin
                bad++;
                $display("FAIL %s resp_hold: data=%h err=%b want data=%h err=0",
                         name, RESP_DATA, RESP_ERR, exp_data);
            end
            check_quiet(name);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        clear_units();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (RESP_DATA !== '0 || RESP_ERR !== 1'b0 || uif.U_A_TDATA !== '0 || uif.U_B_TDATA !== '0) begin
            bad++;
            $display("FAIL reset_data: resp=%h err=%b a=%h b=%h want all 0",
                     RESP_DATA, RESP_ERR, uif.U_A_TDATA, uif.U_B_TDATA);
        end
        check_quiet("reset");
        RST_N = 1'b1;
        @(negedge CLK);
        check_quiet("reset_release");
    endtask

    task automatic test_directed();
        run_txn("fadd", 3'd0, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1, 32'h40400000, 1'b0);
        run_txn("fle_b_late", 3'd6, 32'h3F800000, 32'h40000000, 0, 3, 0, 0, 0, 32'h00000001, 1'b0);
        run_txn("fdiv_early_r", 3'd3, 32'h40800000, 32'h40000000, 0, 4, 0, 1, 0, 32'h40000000, 1'b0);
        run_txn("illegal", 3'd7, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1'b0);
        run_txn("feq_noise", 3'd4, 32'h3F800000, 32'h3F800000, 1, 0, 2, 0, 2, 32'hFFFFFFFE, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn("random", 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_fmul", 3'd2, 32'h40000000, 32'h40400000, 0, 0, 0, 1, 0, 32'h40C00000, 1'b0);
        run_txn("b2b_flt", 3'd5, 32'h40000000, 32'h3F800000, 0, 0, 0, 1, 0, 32'h00000000, 1'b0);
        run_txn("b2b_fsub", 3'd1, 32'h40400000, 32'h3F800000, 2, 2, 2, 0, 0, 32'h40000000, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("fmul_timeout", 3'd2, 32'h40000000, 32'h40000000, 0, 0, 0, 2, 0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        REQ_VALID = 1'b1; REQ_OP = 3'd1; REQ_A = 32'h40400000; REQ_B = 32'h3F800000;
        uif.U_A_TREADY = 4'hF; uif.U_B_TREADY = 4'hF; uif.U_OP_TREADY = 2'h3;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (4) @(negedge CLK);            // operands taken, result withheld
        total++;
        if (BUSY !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_busy: busy=%b want 1", BUSY);
        end
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check_quiet("reset_mid");
        @(negedge CLK);
        RST_N = 1'b1;
        clear_units();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_quiet("reset_mid_after");
        end
    endtask

    initial begin
        clear_units();
        @(negedge CLK);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
